control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 46 ++++
 rtl/control_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/control_unit_pkg.sv
//------------------------------------------------------------------------------
// Module   : control_unit_pkg
// Purpose  : Shared processor encodings: opcodes, control states, bus selects.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package control_unit_pkg;

  localparam int c_op_w = 4;

  localparam logic [c_op_w-1:0] c_op_nop = 4'd0;
  localparam logic [c_op_w-1:0] c_op_add = 4'd1;
  localparam logic [c_op_w-1:0] c_op_sub = 4'd2;
  localparam logic [c_op_w-1:0] c_op_and = 4'd3;
  localparam logic [c_op_w-1:0] c_op_not = 4'd4;
  localparam logic [c_op_w-1:0] c_op_rd  = 4'd5;
  localparam logic [c_op_w-1:0] c_op_wr  = 4'd6;
  localparam logic [c_op_w-1:0] c_op_br  = 4'd7;
  localparam logic [c_op_w-1:0] c_op_brz = 4'd8;

  localparam logic [2:0] c_bus1_r0 = 3'd0;
  localparam logic [2:0] c_bus1_pc = 3'd4;

  localparam logic [1:0] c_bus2_alu  = 2'd0;
  localparam logic [1:0] c_bus2_bus1 = 2'd1;
  localparam logic [1:0] c_bus2_mem  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

endpackage

`default_nettype wire

// File: rtl/control_unit.sv
//------------------------------------------------------------------------------
// Module   : control_unit
// Purpose  : Multi-cycle instruction sequencer driving datapath strobes/muxes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_unit
  import control_unit_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int OP_SIZE   = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [WORD_SIZE-1:0] instruction,
  input  logic                 zero,
  output logic [3:0]           load_r,
  output logic                 load_pc,
  output logic                 inc_pc,
  output logic                 load_ir,
  output logic                 load_add_r,
  output logic                 load_reg_y,
  output logic                 load_reg_z,
  output logic                 write,
  output logic [2:0]           sel_bus1,
  output logic [1:0]           sel_bus2
);

  state_t r_state;
  state_t w_next;

  logic [OP_SIZE-1:0] w_opcode;
  logic [1:0]         w_src;
  logic [1:0]         w_dest;
  logic [3:0]         w_dest_sel;

  assign w_opcode   = instruction[WORD_SIZE-1 -: OP_SIZE];
  assign w_src      = instruction[3:2];
  assign w_dest     = instruction[1:0];
  assign w_dest_sel = 4'b0001 << w_dest;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = S_HALT;
    load_r     = 4'b0000;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    write      = 1'b0;
    sel_bus1   = c_bus1_r0;
    sel_bus2   = c_bus2_alu;

    case (r_state)
      S_IDLE: w_next = S_FET1;

      S_FET1: begin
        sel_bus1   = c_bus1_pc;
        sel_bus2   = c_bus2_bus1;
        load_add_r = 1'b1;
        w_next     = S_FET2;
      end

      S_FET2: begin
        sel_bus2 = c_bus2_mem;
        load_ir  = 1'b1;
        inc_pc   = 1'b1;
        w_next   = S_DEC;
      end

      S_DEC: begin
        case (w_opcode)
          c_op_nop: w_next = S_FET1;
          c_op_add, c_op_sub, c_op_and: begin
            sel_bus1   = {1'b0, w_src};
            sel_bus2   = c_bus2_bus1;
            load_reg_y = 1'b1;
            w_next     = S_EX1;
          end
          c_op_not: begin
            sel_bus1   = {1'b0, w_src};
            sel_bus2   = c_bus2_alu;
            load_reg_z = 1'b1;
            load_r     = w_dest_sel;
            w_next     = S_FET1;
          end
          c_op_rd, c_op_wr, c_op_br, c_op_brz: begin
            // Not-taken BRZ only steps the PC past the trailing address byte
            if (w_opcode == c_op_brz && !zero) begin
              inc_pc = 1'b1;
              w_next = S_FET1;
            end else begin
              sel_bus1   = c_bus1_pc;
              sel_bus2   = c_bus2_bus1;
              load_add_r = 1'b1;
              if (w_opcode == c_op_rd)      w_next = S_RD1;
              else if (w_opcode == c_op_wr) w_next = S_WR1;
              else                          w_next = S_BR1;
            end
          end
          default: w_next = S_HALT;
        endcase
      end

      S_EX1: begin
        sel_bus1   = {1'b0, w_dest};
        sel_bus2   = c_bus2_alu;
        load_reg_z = 1'b1;
        load_r     = w_dest_sel;
        w_next     = S_FET1;
      end

      S_RD1, S_WR1: begin
        sel_bus2   = c_bus2_mem;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
        w_next     = (r_state == S_RD1) ? S_RD2 : S_WR2;
      end

      S_RD2: begin
        sel_bus2 = c_bus2_mem;
        load_r   = w_dest_sel;
        w_next   = S_FET1;
      end

      S_WR2: begin
        sel_bus1 = {1'b0, w_src};
        write    = 1'b1;
        w_next   = S_FET1;
      end

      S_BR1: begin
        sel_bus2   = c_bus2_mem;
        load_add_r = 1'b1;
        w_next     = S_BR2;
      end

      S_BR2: begin
        sel_bus2 = c_bus2_mem;
        load_pc  = 1'b1;
        w_next   = S_FET1;
      end

      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

endmodule

`default_nettype wire
